// File: rtl/mem_access_unit.sv
// mem_access_unit: turns single-cycle controller memory intents into req/ack
// transactions on a shared memory, owning IR/MDR and stalling the controller.
module mem_access_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              AdrSrc,
    input  logic              IRWrite,
    input  logic              MDRWrite,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALUAddr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              Stall,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] MDR,
    output logic [3:0]        opcode,
    output logic [8:0]        func,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state, next;
    logic [CW-1:0] cnt;
    logic          tgt_ir, tgt_mdr;
    logic          access, conflict, abort;

    assign access   = IRWrite | MDRWrite | MemWrite;
    assign conflict = (IRWrite & MDRWrite) | (IRWrite & MemWrite) | (MDRWrite & MemWrite);
    assign abort    = !mem_ack && cnt == CW'(TIMEOUT - 1);
    assign opcode   = IR[15:12];
    assign func     = IR[8:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    // Stall is gated by rst so the controller is never frozen while in reset.
    always_comb begin
        next    = state;
        Stall   = 1'b0;
        mem_req = 1'b0;
        case (state)
            IDLE: begin
                Stall = rst & access;
                next  = access ? REQ : IDLE;
            end
            REQ: begin
                Stall   = 1'b1;
                mem_req = 1'b1;
                next    = (mem_ack || abort) ? DONE : REQ;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            IR        <= '0;
            MDR       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            cnt       <= '0;
            tgt_ir    <= 1'b0;
            tgt_mdr   <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_ack || conflict) err <= 1'b1;
                    if (access) begin
                        mem_addr  <= AdrSrc ? ALUAddr : PC;
                        mem_we    <= MemWrite;
                        mem_wdata <= WriteData;
                        tgt_ir    <= !MemWrite && IRWrite;
                        tgt_mdr   <= !MemWrite && !IRWrite && MDRWrite;
                        cnt       <= '0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (tgt_ir)  IR  <= mem_rdata;
                        if (tgt_mdr) MDR <= mem_rdata;
                    end else if (abort) begin
                        err <= 1'b1;
                        cnt <= CW'(TIMEOUT);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: if (mem_ack) err <= 1'b1;
            endcase
        end
    end
endmodule
